// File: rtl/prog_loader_if.sv
// Byte-stream, memory-port-2 and status bundle between the loader and its environment.
// master: byte source / system side; slave: the loader itself.
interface prog_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_en;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_din, mem_en, mem_we,
        input  busy, done, error, cpu_hold
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_addr, mem_din, mem_en, mem_we,
        output busy, done, error, cpu_hold
    );
endinterface

// File: rtl/prog_loader.sv
// Purpose: assembles an LE byte stream into 32-bit words, writes them via memory port 2, gates the CPU (LOADER_CHECKSUM_EN adds a trailing sum byte).
// Latency: write strobe the cycle after a word's 4th byte; DONE/ERR the cycle after the last write, oversize header or checksum byte.
// Backpressure: byte_ready is low in IDLE/WRITE/DONE/ERR, so the source holds its byte across each write cycle.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [31:0] ADDR_STEP = 32'd1,
    parameter logic [31:0] MAX_WORDS = 32'd1000
) (
    input  logic         clock,
    input  logic         reset_n,
    prog_loader_if.slave ld
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CSUM;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] n_q, n_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        xfer;
    logic [31:0] shifted;

    assign xfer    = ld.byte_valid && ld.byte_ready;
    // Previous three bytes sit below the new one, so the first byte lands in [7:0].
    assign shifted = {ld.byte_in, word_q};

    assign ld.mem_addr = mem_addr_q;
    assign ld.mem_din  = mem_din_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            waddr_q    <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            waddr_q    <= waddr_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        n_d           = n_q;
        idx_d         = idx_q;
        waddr_d       = waddr_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        ld.byte_ready = 1'b0;
        ld.busy       = 1'b0;
        ld.done       = 1'b0;
        ld.error      = 1'b0;
        ld.cpu_hold   = 1'b1;
        ld.mem_en     = 1'b0;
        ld.mem_we     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                ld.done     = (state_q == S_DONE);
                ld.error    = (state_q == S_ERR);
                ld.cpu_hold = (state_q != S_DONE);
                if (ld.start) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    idx_d   = '0;
                    waddr_d = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_HDR: begin
                ld.byte_ready = 1'b1;
                ld.busy       = 1'b1;
                if (xfer) begin
                    word_d = shifted[31:8];
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        n_d = shifted;
                        if (shifted > MAX_WORDS)  state_d = S_ERR;
                        else if (shifted == '0)   state_d = S_TAIL;
                        else                      state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                ld.byte_ready = 1'b1;
                ld.busy       = 1'b1;
                if (xfer) begin
                    word_d = shifted[31:8];
                    cnt_d  = cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + ld.byte_in;
`endif
                    if (cnt_q == 2'd3) begin
                        mem_din_d  = shifted;
                        mem_addr_d = waddr_q;
                        state_d    = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                ld.busy   = 1'b1;
                ld.mem_en = 1'b1;
                ld.mem_we = 1'b1;
                idx_d     = idx_q + 32'd1;
                waddr_d   = waddr_q + ADDR_STEP;
                state_d   = (idx_q + 32'd1 == n_q) ? S_TAIL : S_DATA;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                ld.byte_ready = 1'b1;
                ld.busy       = 1'b1;
                if (xfer) state_d = (ld.byte_in == sum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end
endmodule
